// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID source that depends on the load in EX.
import hazard_pkg::*;

module load_use_detect (
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       lu
);

   // $zero is never a real dependency even if a load targets it.
   assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller with memory-wait watchdog.
// Optional HAZARD_STATS_EN adds stall_cnt / flush_cnt statistics ports.
import hazard_pkg::*;

module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        ex_branch_taken,
   input  logic        mem_busy,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        back_write,
   output logic        err
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT = CW'(MEM_TIMEOUT);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          lu;

   load_use_detect u_lu (
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .lu          (lu)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_busy) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= CW'(1);
               end
            end
            MEM_WAIT: begin
               if (!mem_busy) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt < TIMEOUT) begin
                  wait_cnt <= wait_cnt + CW'(1);
               end else begin
                  state <= ERR;
               end
            end
            ERR: state <= ERR;
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // RUN and MEM_WAIT share the priority list; MEM_WAIT only differs in next state.
   always_comb begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      back_write  = 1'b0;
      err         = (state == ERR);
      if (!rst && (state != ERR) && !mem_busy) begin
         if (ex_branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            back_write  = 1'b1;
         end else if (lu) begin
            id_ex_flush = 1'b1;
            back_write  = 1'b1;
         end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            back_write  = 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && (state != ERR))
            stall_cnt <= stall_cnt + 32'd1;
         if (if_id_flush)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences, random vs model.
module tb_hazard_ctrl;

   localparam int unsigned TO = 4;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       mem_read;
      logic [4:0] ex_rt;
      logic       br;
      logic       busy;
   } in_t;

   typedef struct {
      in_t        in;
      logic [5:0] exp;
   } vec_t;

   // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write, err}
   localparam logic [5:0] O_NORM = 6'b110010;
   localparam logic [5:0] O_LU   = 6'b000110;
   localparam logic [5:0] O_BR   = 6'b111110;
   localparam logic [5:0] O_FRZ  = 6'b000000;
   localparam logic [5:0] O_ERR  = 6'b000001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
   logic pc_write, if_id_write, if_id_flush, id_ex_flush, back_write, err;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model state: consecutive busy edges seen, trap flag, statistics.
   int unsigned busy_run = 0;
   bit          trapped  = 0;
   int unsigned m_stall  = 0;
   int unsigned m_flush  = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .ex_mem_read     (ex_mem_read),
      .ex_rt           (ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .mem_busy        (mem_busy),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .back_write      (back_write),
      .err             (err)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   function automatic logic [5:0] model_out(input in_t v);
      bit hit;
      hit = v.mem_read && (v.ex_rt != 0) &&
            ((v.ex_rt == v.rs) || (v.uses_rt && (v.ex_rt == v.rt)));
      if (trapped)     return O_ERR;
      if (v.busy)      return O_FRZ;
      if (v.br)        return O_BR;
      if (hit)         return O_LU;
      return O_NORM;
   endfunction

   function automatic logic [5:0] dut_out();
      return {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write, err};
   endfunction

   task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_stats(input string name);
`ifdef HAZARD_STATS_EN
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
         failures++;
         $display("FAIL %s stall_cnt=%0d exp=%0d flush_cnt=%0d exp=%0d",
                  name, stall_cnt, m_stall, flush_cnt, m_flush);
      end
`else
      if (name.len() == 0) $display("unnamed stats point");
`endif
   endtask

   task automatic drive(input in_t v);
      id_rs           = v.rs;
      id_rt           = v.rt;
      id_uses_rt      = v.uses_rt;
      ex_mem_read     = v.mem_read;
      ex_rt           = v.ex_rt;
      ex_branch_taken = v.br;
      mem_busy        = v.busy;
   endtask

   // Advance the model across one rising edge with inputs v applied.
   task automatic model_edge(input in_t v);
      logic [5:0] o;
      o = model_out(v);
      if (!trapped && !o[5]) m_stall++;
      if (o[3]) m_flush++;
      if (!trapped) begin
         if (v.busy) begin
            busy_run++;
            if (busy_run > TO) trapped = 1;
         end else begin
            busy_run = 0;
         end
      end
   endtask

   // Called just after a rising edge: drive, compare mid-cycle, cross next edge.
   task automatic step(input string name, input in_t v, input logic [5:0] exp, input bit use_exp);
      drive(v);
      @(negedge clk);
      check6(name, dut_out(), use_exp ? exp : model_out(v));
      check_stats(name);
      @(posedge clk);
      model_edge(v);
      #1;
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1;
      #2;
      check6(name, dut_out(), O_FRZ);
      busy_run = 0;
      trapped  = 0;
      m_stall  = 0;
      m_flush  = 0;
      check_stats(name);
      rst = 1'b0;
      #1;
   endtask

   function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                              input logic mr, input logic [4:0] er, input logic br,
                              input logic busy);
      in_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = uses; v.mem_read = mr;
      v.ex_rt = er; v.br = br; v.busy = busy;
      return v;
   endfunction

   vec_t tbl[12];
   in_t  idle;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0), O_NORM};
      tbl[1]  = '{mk(5, 0, 0, 1, 5, 0, 0), O_LU};
      tbl[2]  = '{mk(0, 0, 0, 1, 0, 0, 0), O_NORM};
      tbl[3]  = '{mk(3, 5, 0, 1, 5, 0, 0), O_NORM};
      tbl[4]  = '{mk(3, 5, 1, 1, 5, 0, 0), O_LU};
      tbl[5]  = '{mk(5, 0, 0, 1, 5, 1, 0), O_BR};
      tbl[6]  = '{mk(5, 0, 0, 1, 5, 1, 1), O_FRZ};
      tbl[7]  = '{mk(5, 0, 0, 1, 5, 0, 0), O_LU};
      tbl[8]  = '{mk(5, 0, 0, 0, 5, 0, 0), O_NORM};
      tbl[9]  = '{mk(31, 0, 0, 1, 31, 0, 0), O_LU};
      tbl[10] = '{mk(6, 8, 1, 1, 7, 0, 0), O_NORM};
      tbl[11] = '{mk(1, 2, 1, 0, 0, 1, 0), O_BR};

      #2;
      check6("reset_hold", dut_out(), O_FRZ);
      check_stats("reset_hold_stats");
      #5;
      rst = 1'b0;
      #1;

      foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp, 1);

      // Load-use stall lasts one cycle: load moves on, ID then proceeds.
      step("lu_cycle", mk(5, 0, 0, 1, 5, 0, 0), O_LU, 1);
      step("lu_release", mk(5, 0, 0, 0, 0, 0, 0), O_NORM, 1);

      // Busy for exactly TO edges: frozen, no trap.
      for (int unsigned k = 0; k < TO; k++) step("busy_ok", mk(0, 0, 0, 0, 0, 0, 1), O_FRZ, 1);
      step("busy_ok_exit", idle, O_NORM, 1);

      // Busy for TO+1 edges: trap, sticky until reset.
      for (int unsigned k = 0; k < TO + 1; k++) step("busy_trap", mk(0, 0, 0, 0, 0, 0, 1), O_FRZ, 1);
      step("trap_set", idle, O_ERR, 1);
      step("trap_sticky", mk(0, 0, 0, 0, 0, 1, 0), O_ERR, 1);
      do_reset("trap_reset");
      step("after_reset", idle, O_NORM, 1);

      // Reset mid-wait clears the counter: a fresh TO-edge burst must not trap.
      step("wait_pre", mk(0, 0, 0, 0, 0, 0, 1), O_FRZ, 1);
      step("wait_pre", mk(0, 0, 0, 0, 0, 0, 1), O_FRZ, 1);
      do_reset("wait_reset");
      for (int unsigned k = 0; k < TO; k++) step("busy_fresh", mk(0, 0, 0, 0, 0, 0, 1), O_FRZ, 1);
      step("busy_fresh_exit", idle, O_NORM, 1);

      // Statistics: 3 stalls and 2 branch flushes after reset.
      do_reset("stats_reset");
      for (int k = 0; k < 3; k++) begin
         step("stats_lu", mk(9, 0, 0, 1, 9, 0, 0), O_LU, 1);
         step("stats_gap", idle, O_NORM, 1);
      end
      step("stats_br", mk(0, 0, 0, 0, 0, 1, 0), O_BR, 1);
      step("stats_br", mk(0, 0, 0, 0, 0, 1, 0), O_BR, 1);
      drive(idle);
      #1;
`ifdef HAZARD_STATS_EN
      checks++;
      if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
         failures++;
         $display("FAIL stats_total stall_cnt=%0d exp=3 flush_cnt=%0d exp=2", stall_cnt, flush_cnt);
      end
`endif

      // Randomized traffic against the model.
      begin
         int unsigned burst = 0;
         int unsigned trap_age = 0;
         for (int n = 0; n < 600; n++) begin
            in_t v;
            v.rs       = 5'($urandom_range(0, 3));
            v.rt       = 5'($urandom_range(0, 3));
            v.uses_rt  = 1'($urandom_range(0, 1));
            v.mem_read = 1'($urandom_range(0, 1));
            v.ex_rt    = 5'($urandom_range(0, 3));
            v.br       = ($urandom_range(0, 5) == 0);
            if (burst > 0) begin
               v.busy = 1'b1;
               burst--;
            end else if ($urandom_range(0, 9) == 0) begin
               burst  = $urandom_range(0, 6);
               v.busy = 1'b1;
            end else begin
               v.busy = 1'b0;
            end
            trap_age = trapped ? trap_age + 1 : 0;
            if (trap_age > 3 || $urandom_range(0, 59) == 0) begin
               do_reset("rand_reset");
               burst = 0;
               trap_age = 0;
            end
            step("random", v, '0, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
